scaler_cfg_ctrl: RTL and testbench
==================================

// Module: scaler_cfg_ctrl
// PURPOSE
// Frame-synchronous configuration controller for the video scaler. Holds host crop-window writes in staging
// registers and commits them at the next frame sync (vs rising edge), so the scaler never changes settings mid-frame.
// Replaces the combinational scale-factor divides with a serial restoring divider, one quotient bit per cycle.
// Drives input_x/y_res, x/y_scale and scaler_en into the scaler datapath, all in the scaler read-clock domain.
// PARAMETERS
// RES_WIDTH       11    width of start/end coordinates and of resolution-minus-1 values
// OUTPUT_X_RES    1279  output width minus 1
// OUTPUT_Y_RES    719   output height minus 1
// SCALE_INT_BITS  4     integer bits of the scale factor
// SCALE_FRAC_BITS 14    fraction bits of the scale factor; SCALE_BITS = 18
// PORTS
// clk          in   1          scaler clock (post_clk domain)
// rst_n        in   1          asynchronous active-low reset
// cfg_wr       in   1          one-cycle pulse; load cfg_* into staging and set pending
// cfg_start_x  in   RES_WIDTH  window start X
// cfg_start_y  in   RES_WIDTH  window start Y
// cfg_end_x    in   RES_WIDTH  window end X (exclusive); width = end - start
// cfg_end_y    in   RES_WIDTH  window end Y (exclusive)
// cfg_en       in   1          scaler enable (0 = bypass)
// vs           in   1          frame sync, already synchronous to clk
// frame_start  out  1          one-cycle pulse on every detected vs rising edge
// input_x_res  out  RES_WIDTH  active input width minus 1
// input_y_res  out  RES_WIDTH  active input height minus 1
// x_scale      out  SCALE_BITS active X factor, Q4.14
// y_scale      out  SCALE_BITS active Y factor, Q4.14
// scaler_en    out  1          active enable
// cfg_busy     out  1          high from LATCH through COMMIT inclusive
// cfg_err      out  1          sticky error flag; cleared by the next successful commit
// BEHAVIOUR
// - Reset values: input_x_res = OUTPUT_X_RES, input_y_res = OUTPUT_Y_RES, x_scale = y_scale = 18'h04000,
//   scaler_en = 0, cfg_busy = 0, cfg_err = 0, frame_start = 0. Staging registers and the pending flag are cleared.
// - Edge detect: vs is registered into vs_d. vs_rise = vs & ~vs_d. frame_start is registered, so it is high in the
//   cycle after vs_rise.
// - cfg_wr is accepted in any state. It overwrites staging and sets pending. It never touches the active outputs.
// - FSM states and transitions:
//   IDLE: on vs_rise with pending set, go to LATCH.
//   LATCH: copy staging into working registers and clear pending. Compute wx = end_x - start_x and
//     wy = end_y - start_y (unsigned, RES_WIDTH+1 bits).
//     If end_x <= start_x or end_y <= start_y, set cfg_err and return to IDLE; the active config is unchanged.
//     Otherwise go to DIV_X.
//   DIV_X: 18 cycles. Computes q = floor((wx << 14) / (OUTPUT_X_RES + 1)) by restoring division.
//     Remainder is initialised to wx >> 4. Each cycle shifts in the next dividend bit, compares and subtracts.
//     Saturation: if wx >= (OUTPUT_X_RES + 1) << 4, the result is forced to 18'h3FFFF. The divider still runs
//     18 cycles, so latency stays fixed.
//   DIV_Y: 18 cycles, same method with wy and OUTPUT_Y_RES.
//   COMMIT: in a single cycle, update input_x_res = wx - 1, input_y_res = wy - 1, x_scale, y_scale and
//     scaler_en, and clear cfg_err. Then go to IDLE.
// - Latency: vs_rise cycle = T. LATCH at T+1, DIV_X at T+2..T+19, DIV_Y at T+20..T+37, COMMIT at T+38.
//   The new outputs are visible from T+39. cfg_busy is high for T+1..T+38.
// - vs_rise while busy: frame_start still pulses; the FSM ignores the edge and keeps the update in progress.
// - cfg_wr while busy: the update in progress uses the configuration already latched. The new write sets pending
//   and is applied at the next vs_rise after IDLE is reached.
// - Simultaneous cfg_wr and vs_rise in IDLE: the new cfg_wr value is what LATCH captures.
// - Reset mid-update: all outputs return to their reset values immediately, and the partial result is discarded.
// TESTING
// - Reset, then cfg_wr window (0,0)-(640,360) en=1, then vs rise -> at T+39: input_x_res=639, input_y_res=359,
//   x_scale=y_scale=18'h02000, scaler_en=1.
// - Window (0,0)-(1920,1080) -> x_scale=y_scale=18'h06000, input_x_res=1919, input_y_res=1079;
//   cfg_busy high for exactly 38 cycles.
// - cfg_wr end_x=100 start_x=100 -> after vs rise: cfg_err=1 at T+2; outputs keep previous values;
//   a later valid commit clears cfg_err.
// - OUTPUT_X_RES=0, window width 32 -> x_scale=18'h3FFFF (saturated); latency still 38 cycles.
// - cfg_wr (0,0)-(640,360) during DIV_X of the (0,0)-(1920,1080) update -> first commit gives 18'h06000;
//   the next vs rise commits 18'h02000.
// - rst_n low at T+10 of an update -> outputs immediately return to reset values; no commit occurs without
//   a new cfg_wr.

Source files
------------

// File: rtl/scaler_cfg_ctrl.sv
// Frame-synchronous crop/scale configuration controller: stages host writes, commits on vs rising edge,
// and computes Q4.14 scale factors with a shared serial restoring divider.
module scaler_cfg_ctrl #(
    parameter int RES_WIDTH       = 11,
    parameter int OUTPUT_X_RES    = 1279,
    parameter int OUTPUT_Y_RES    = 719,
    parameter int SCALE_INT_BITS  = 4,
    parameter int SCALE_FRAC_BITS = 14
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      cfg_wr,
    input  logic [RES_WIDTH-1:0]                      cfg_start_x,
    input  logic [RES_WIDTH-1:0]                      cfg_start_y,
    input  logic [RES_WIDTH-1:0]                      cfg_end_x,
    input  logic [RES_WIDTH-1:0]                      cfg_end_y,
    input  logic                                      cfg_en,
    input  logic                                      vs,
    output logic                                      frame_start,
    output logic [RES_WIDTH-1:0]                      input_x_res,
    output logic [RES_WIDTH-1:0]                      input_y_res,
    output logic [SCALE_INT_BITS+SCALE_FRAC_BITS-1:0] x_scale,
    output logic [SCALE_INT_BITS+SCALE_FRAC_BITS-1:0] y_scale,
    output logic                                      scaler_en,
    output logic                                      cfg_busy,
    output logic                                      cfg_err
);
    localparam int SCALE_BITS = SCALE_INT_BITS + SCALE_FRAC_BITS;
    localparam int W          = RES_WIDTH + 1;
    localparam int REM_W      = RES_WIDTH + 2;
    localparam int CNT_W      = $clog2(SCALE_BITS) + 1;
    localparam logic [REM_W-1:0] DIV_X_D = REM_W'(OUTPUT_X_RES + 1);
    localparam logic [REM_W-1:0] DIV_Y_D = REM_W'(OUTPUT_Y_RES + 1);
    localparam int unsigned SAT_X = (OUTPUT_X_RES + 1) << SCALE_INT_BITS;
    localparam int unsigned SAT_Y = (OUTPUT_Y_RES + 1) << SCALE_INT_BITS;
    localparam logic [SCALE_BITS-1:0] SCALE_ONE = SCALE_BITS'(1) << SCALE_FRAC_BITS;

    typedef enum logic [2:0] {IDLE, LATCH, DIV_X, DIV_Y, COMMIT} state_t;
    state_t state, state_nxt;

    logic                  vs_d, vs_rise, pending;
    logic [RES_WIDTH-1:0]  stg_sx, stg_sy, stg_ex, stg_ey;
    logic                  stg_en, en_w;
    logic [W-1:0]          wx, wy, lat_wx, lat_wy;
    logic                  lat_bad;
    logic [REM_W-1:0]      rem, rem_nxt, trial, div_d;
    logic                  ge, div_last;
    logic [SCALE_BITS-1:0] dvd, quo, quo_nxt, xq, yq;
    logic [CNT_W-1:0]      cnt;

    assign vs_rise  = vs & ~vs_d;
    assign cfg_busy = (state != IDLE);
    assign lat_wx   = {1'b0, stg_ex} - {1'b0, stg_sx};
    assign lat_wy   = {1'b0, stg_ey} - {1'b0, stg_sy};
    assign lat_bad  = (stg_ex <= stg_sx) || (stg_ey <= stg_sy);

    // One restoring step: shift in the next dividend bit, subtract the divisor when it fits.
    assign div_d    = (state == DIV_Y) ? DIV_Y_D : DIV_X_D;
    assign trial    = {rem[REM_W-2:0], dvd[SCALE_BITS-1]};
    assign ge       = (trial >= div_d);
    assign rem_nxt  = ge ? (trial - div_d) : trial;
    assign quo_nxt  = {quo[SCALE_BITS-2:0], ge};
    assign div_last = (cnt == CNT_W'(SCALE_BITS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_rise && (pending || cfg_wr)) state_nxt = LATCH;
            LATCH:   state_nxt = lat_bad ? IDLE : DIV_X;
            DIV_X:   if (div_last) state_nxt = DIV_Y;
            DIV_Y:   if (div_last) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d        <= 1'b0;
            frame_start <= 1'b0;
            pending     <= 1'b0;
            stg_sx      <= '0;
            stg_sy      <= '0;
            stg_ex      <= '0;
            stg_ey      <= '0;
            stg_en      <= 1'b0;
            wx          <= '0;
            wy          <= '0;
            en_w        <= 1'b0;
            rem         <= '0;
            dvd         <= '0;
            quo         <= '0;
            xq          <= '0;
            yq          <= '0;
            cnt         <= '0;
            input_x_res <= RES_WIDTH'(OUTPUT_X_RES);
            input_y_res <= RES_WIDTH'(OUTPUT_Y_RES);
            x_scale     <= SCALE_ONE;
            y_scale     <= SCALE_ONE;
            scaler_en   <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            vs_d        <= vs;
            frame_start <= vs_rise;
            if (cfg_wr) begin
                stg_sx  <= cfg_start_x;
                stg_sy  <= cfg_start_y;
                stg_ex  <= cfg_end_x;
                stg_ey  <= cfg_end_y;
                stg_en  <= cfg_en;
                pending <= 1'b1;
            end else if (state == LATCH) begin
                pending <= 1'b0;
            end
            case (state)
                LATCH: begin
                    wx   <= lat_wx;
                    wy   <= lat_wy;
                    en_w <= stg_en;
                    rem  <= REM_W'(lat_wx >> SCALE_INT_BITS);
                    dvd  <= {lat_wx[SCALE_INT_BITS-1:0], {SCALE_FRAC_BITS{1'b0}}};
                    quo  <= '0;
                    cnt  <= '0;
                    if (lat_bad) cfg_err <= 1'b1;
                end
                DIV_X, DIV_Y: begin
                    rem <= rem_nxt;
                    dvd <= dvd << 1;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (div_last) begin
                        // X result done: reload the shared divider with the Y dividend.
                        if (state == DIV_X) xq <= quo_nxt;
                        else                yq <= quo_nxt;
                        rem <= REM_W'(wy >> SCALE_INT_BITS);
                        dvd <= {wy[SCALE_INT_BITS-1:0], {SCALE_FRAC_BITS{1'b0}}};
                        quo <= '0;
                        cnt <= '0;
                    end
                end
                COMMIT: begin
                    input_x_res <= RES_WIDTH'(wx - 1'b1);
                    input_y_res <= RES_WIDTH'(wy - 1'b1);
                    x_scale     <= (32'(wx) >= SAT_X) ? '1 : xq;
                    y_scale     <= (32'(wy) >= SAT_Y) ? '1 : yq;
                    scaler_en   <= en_w;
                    cfg_err     <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_scaler_cfg_ctrl.sv
// Self-checking bench for scaler_cfg_ctrl: directed scenarios plus randomized windows against
// an arithmetic reference model; a second instance uses OUTPUT_X_RES=0 to exercise saturation.
module tb_scaler_cfg_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [10:0] cfg_start_x = '0, cfg_start_y = '0, cfg_end_x = '0, cfg_end_y = '0;
    logic        cfg_en = 1'b0;
    logic        vs = 1'b0;

    logic        frame_start, scaler_en, cfg_busy, cfg_err;
    logic [10:0] input_x_res, input_y_res;
    logic [17:0] x_scale, y_scale;
    logic        s_frame_start, s_scaler_en, s_cfg_busy, s_cfg_err;
    logic [10:0] s_input_x_res, s_input_y_res;
    logic [17:0] s_x_scale, s_y_scale;

    int n_checks = 0;
    int n_errors = 0;
    int bc;

    // reference model state
    int unsigned m_xres, m_yres, m_xs, m_ys, m_sxs, m_en, m_err;

    always #5 clk = ~clk;

    scaler_cfg_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr),
        .cfg_start_x(cfg_start_x), .cfg_start_y(cfg_start_y),
        .cfg_end_x(cfg_end_x), .cfg_end_y(cfg_end_y), .cfg_en(cfg_en), .vs(vs),
        .frame_start(frame_start), .input_x_res(input_x_res), .input_y_res(input_y_res),
        .x_scale(x_scale), .y_scale(y_scale), .scaler_en(scaler_en),
        .cfg_busy(cfg_busy), .cfg_err(cfg_err)
    );

    scaler_cfg_ctrl #(.OUTPUT_X_RES(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr),
        .cfg_start_x(cfg_start_x), .cfg_start_y(cfg_start_y),
        .cfg_end_x(cfg_end_x), .cfg_end_y(cfg_end_y), .cfg_en(cfg_en), .vs(vs),
        .frame_start(s_frame_start), .input_x_res(s_input_x_res), .input_y_res(s_input_y_res),
        .x_scale(s_x_scale), .y_scale(s_y_scale), .scaler_en(s_scaler_en),
        .cfg_busy(s_cfg_busy), .cfg_err(s_cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_scale(input int unsigned w, input int unsigned d);
        if (w >= d * 16) return 32'h3FFFF;
        return (w * 16384) / d;
    endfunction

    task automatic model_reset();
        m_xres = 1279; m_yres = 719; m_xs = 16384; m_ys = 16384; m_sxs = 16384;
        m_en = 0; m_err = 0;
    endtask

    task automatic model_apply(input int unsigned sx, sy, ex, ey, en);
        if (ex <= sx || ey <= sy) begin
            m_err = 1;
        end else begin
            m_xres = ex - sx - 1;
            m_yres = ey - sy - 1;
            m_xs   = ref_scale(ex - sx, 1280);
            m_ys   = ref_scale(ey - sy, 720);
            m_sxs  = ref_scale(ex - sx, 1);
            m_en   = en;
            m_err  = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_count();
        step();
        if (cfg_busy) bc++;
    endtask

    task automatic write_cfg(input int unsigned sx, sy, ex, ey, en);
        cfg_start_x = 11'(sx); cfg_start_y = 11'(sy);
        cfg_end_x = 11'(ex);   cfg_end_y = 11'(ey);
        cfg_en = en[0];
        cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".xres"}, 32'(input_x_res), m_xres);
        check({tag, ".yres"}, 32'(input_y_res), m_yres);
        check({tag, ".xs"}, 32'(x_scale), m_xs);
        check({tag, ".ys"}, 32'(y_scale), m_ys);
        check({tag, ".en"}, 32'(scaler_en), m_en);
        check({tag, ".err"}, 32'(cfg_err), m_err);
        check({tag, ".sat_xs"}, 32'(s_x_scale), m_sxs);
    endtask

    task automatic run_vs(input string tag, input int exp_busy);
        int guard;
        bc = 0;
        vs = 1'b1;
        step_count();
        vs = 1'b0;
        check({tag, ".fs"}, 32'(frame_start), 1);
        guard = 0;
        while (cfg_busy && guard < 100) begin
            step_count();
            guard++;
        end
        check({tag, ".busy_cycles"}, bc, exp_busy);
        check({tag, ".sat_busy"}, 32'(s_cfg_busy), 0);
    endtask

    initial begin
        int guard;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst.fs", 32'(frame_start), 0);
        check("rst.busy", 32'(cfg_busy), 0);
        check("rst.sat_xres", 32'(s_input_x_res), 0);
        check_outputs("rst");

        write_cfg(0, 0, 640, 360, 1);
        model_apply(0, 0, 640, 360, 1);
        run_vs("w640", 38);
        check_outputs("w640");
        check("w640.xs_const", 32'(x_scale), 32'h02000);

        write_cfg(0, 0, 1920, 1080, 1);
        model_apply(0, 0, 1920, 1080, 1);
        run_vs("w1920", 38);
        check_outputs("w1920");
        check("w1920.ys_const", 32'(y_scale), 32'h06000);

        write_cfg(0, 0, 32, 360, 0);
        model_apply(0, 0, 32, 360, 0);
        run_vs("sat32", 38);
        check_outputs("sat32");
        check("sat32.sat_const", 32'(s_x_scale), 32'h3FFFF);

        // zero-width window: error, previous config kept
        write_cfg(100, 0, 100, 360, 1);
        model_apply(100, 0, 100, 360, 1);
        run_vs("err", 1);
        check_outputs("err");
        write_cfg(0, 0, 640, 360, 1);
        model_apply(0, 0, 640, 360, 1);
        run_vs("errclr", 38);
        check_outputs("errclr");

        // write and vs edge during an update in progress
        write_cfg(0, 0, 1920, 1080, 1);
        bc = 0;
        vs = 1'b1;
        step_count();
        vs = 1'b0;
        repeat (5) step_count();
        cfg_start_x = 11'd0; cfg_start_y = 11'd0; cfg_end_x = 11'd640; cfg_end_y = 11'd360;
        cfg_en = 1'b1; cfg_wr = 1'b1;
        step_count();
        cfg_wr = 1'b0;
        vs = 1'b1;
        step_count();
        vs = 1'b0;
        check("mid.fs_busy", 32'(frame_start), 1);
        guard = 0;
        while (cfg_busy && guard < 100) begin
            step_count();
            guard++;
        end
        check("mid.busy_cycles", bc, 38);
        model_apply(0, 0, 1920, 1080, 1);
        check_outputs("mid1");
        model_apply(0, 0, 640, 360, 1);
        run_vs("mid2", 38);
        check_outputs("mid2");

        // reset in the middle of an update
        write_cfg(0, 0, 1920, 1080, 1);
        vs = 1'b1;
        step();
        vs = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rstmid.busy", 32'(cfg_busy), 0);
        check_outputs("rstmid");
        #2;
        rst_n = 1'b1;
        step();
        bc = 0;
        vs = 1'b1;
        step_count();
        vs = 1'b0;
        repeat (50) step_count();
        check("rstmid.no_update", bc, 0);
        check_outputs("rstmid_after");

        for (int i = 0; i < 25; i++) begin
            int unsigned sx, sy, ex, ey, en, bad;
            bad = ($urandom_range(0, 4) == 0) ? 1 : 0;
            sx = $urandom_range(0, 1000);
            sy = $urandom_range(0, 1000);
            ex = $urandom_range(sx + 1, 2047);
            ey = $urandom_range(sy + 1, 2047);
            if (bad != 0) begin
                if ($urandom_range(0, 1) == 0) ex = $urandom_range(0, sx);
                else                           ey = $urandom_range(0, sy);
            end
            en = $urandom_range(0, 1);
            write_cfg(sx, sy, ex, ey, en);
            model_apply(sx, sy, ex, ey, en);
            run_vs($sformatf("rnd%0d", i), (bad != 0) ? 1 : 38);
            check_outputs($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
